// File: rtl/racer_state_sched.sv
// Double-buffered racer state: game logic stages one update into a shadow
// register, which is committed to the render-facing outputs once per frame.
module racer_state_sched #(
    parameter int COMMIT_V = 749,
    parameter int VIEW_H0  = 512,
    parameter int VIEW_H1  = 1023,
    parameter int VIEW_V1  = 383
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        freeze_in,
    input  logic        upd_valid_in,
    output logic        upd_ready_out,
    input  logic [8:0]  upd_direction_in,
    input  logic [10:0] upd_player_x_in,
    input  logic [10:0] upd_player_y_in,
    input  logic [10:0] upd_opponent_x_in,
    input  logic [10:0] upd_opponent_y_in,
    output logic [8:0]  direction_out,
    output logic [10:0] player_x_out,
    output logic [10:0] player_y_out,
    output logic [10:0] opponent_x_out,
    output logic [10:0] opponent_y_out,
    output logic        commit_out,
    output logic        view_active_out,
    output logic [15:0] frame_count_out,
    output logic [7:0]  stale_count_out
);

    localparam logic [9:0]  COMMIT_LINE = 10'(COMMIT_V);
    localparam logic [10:0] H0          = 11'(VIEW_H0);
    localparam logic [10:0] H1          = 11'(VIEW_H1);
    localparam logic [9:0]  V1          = 10'(VIEW_V1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_next;

    logic        commit_point;
    logic        frame_tick;
    logic        do_capture;
    logic        do_commit;
    logic        do_stale;
    logic        in_view;
    logic [8:0]  dir_norm;

    logic [8:0]  shadow_dir;
    logic [10:0] shadow_px, shadow_py, shadow_ox, shadow_oy;

    // Commit sits on a line well past the visible area so trig ROM lookups
    // driven by the new direction have settled before line 0 is drawn.
    assign commit_point = (hcount_in == 11'd0) && (vcount_in == COMMIT_LINE);
    assign frame_tick   = commit_point && !freeze_in;
    assign in_view      = (hcount_in >= H0) && (hcount_in <= H1) && (vcount_in <= V1);
    assign dir_norm     = (upd_direction_in >= 9'd360) ? (upd_direction_in - 9'd360)
                                                       : upd_direction_in;
    assign upd_ready_out = (state == EMPTY);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= EMPTY;
        else           state <= state_next;
    end

    // A capture coinciding with a commit point still counts that point as
    // stale; the fresh update waits for the following frame.
    always_comb begin
        state_next = state;
        do_capture = 1'b0;
        do_commit  = 1'b0;
        do_stale   = 1'b0;
        case (state)
            EMPTY: begin
                do_stale = frame_tick;
                if (upd_valid_in) begin
                    do_capture = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (frame_tick) begin
                    do_commit  = 1'b1;
                    state_next = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_dir <= '0;
            shadow_px  <= '0;
            shadow_py  <= '0;
            shadow_ox  <= '0;
            shadow_oy  <= '0;
        end else if (do_capture) begin
            shadow_dir <= dir_norm;
            shadow_px  <= upd_player_x_in;
            shadow_py  <= upd_player_y_in;
            shadow_ox  <= upd_opponent_x_in;
            shadow_oy  <= upd_opponent_y_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            direction_out  <= '0;
            player_x_out   <= '0;
            player_y_out   <= '0;
            opponent_x_out <= '0;
            opponent_y_out <= '0;
        end else if (do_commit) begin
            direction_out  <= shadow_dir;
            player_x_out   <= shadow_px;
            player_y_out   <= shadow_py;
            opponent_x_out <= shadow_ox;
            opponent_y_out <= shadow_oy;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            commit_out      <= 1'b0;
            view_active_out <= 1'b0;
            frame_count_out <= '0;
            stale_count_out <= '0;
        end else begin
            commit_out      <= do_commit;
            view_active_out <= in_view;
            if (frame_tick)
                frame_count_out <= frame_count_out + 16'd1;
            if (do_stale && (stale_count_out != 8'hFF))
                stale_count_out <= stale_count_out + 8'd1;
        end
    end

endmodule

// File: tb/tb_racer_state_sched.sv
// Randomized and directed bench for racer_state_sched against a frame-level
// model of staged updates, commits and counters.
module tb_racer_state_sched;

    localparam int COMMIT_V = 749;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        freeze_in;
    logic        upd_valid_in;
    logic        upd_ready_out;
    logic [8:0]  upd_direction_in;
    logic [10:0] upd_player_x_in, upd_player_y_in, upd_opponent_x_in, upd_opponent_y_in;
    logic [8:0]  direction_out;
    logic [10:0] player_x_out, player_y_out, opponent_x_out, opponent_y_out;
    logic        commit_out;
    logic        view_active_out;
    logic [15:0] frame_count_out;
    logic [7:0]  stale_count_out;

    int checks = 0;
    int errors = 0;

    racer_state_sched #(
        .COMMIT_V(COMMIT_V), .VIEW_H0(512), .VIEW_H1(1023), .VIEW_V1(383)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .freeze_in(freeze_in),
        .upd_valid_in(upd_valid_in), .upd_ready_out(upd_ready_out),
        .upd_direction_in(upd_direction_in),
        .upd_player_x_in(upd_player_x_in), .upd_player_y_in(upd_player_y_in),
        .upd_opponent_x_in(upd_opponent_x_in), .upd_opponent_y_in(upd_opponent_y_in),
        .direction_out(direction_out),
        .player_x_out(player_x_out), .player_y_out(player_y_out),
        .opponent_x_out(opponent_x_out), .opponent_y_out(opponent_y_out),
        .commit_out(commit_out), .view_active_out(view_active_out),
        .frame_count_out(frame_count_out), .stale_count_out(stale_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: at most one pending update plus the values on screen.
    bit m_pending;
    int m_stage[5];
    int m_show[5];
    bit m_commit, m_view;
    int m_frames, m_stale;

    function automatic void model_reset();
        m_pending = 0;
        for (int i = 0; i < 5; i++) begin m_stage[i] = 0; m_show[i] = 0; end
        m_commit = 0; m_view = 0; m_frames = 0; m_stale = 0;
    endfunction

    function automatic void model_clock();
        bit at_commit = (hcount_in == 0) && (int'(vcount_in) == COMMIT_V) && !freeze_in;
        bit was_pending = m_pending;
        m_view   = (hcount_in >= 512) && (hcount_in <= 1023) && (vcount_in <= 383);
        m_commit = at_commit && was_pending;
        if (at_commit) m_frames = (m_frames + 1) % 65536;
        if (at_commit && was_pending) begin
            m_show    = m_stage;
            m_pending = 0;
        end
        if (at_commit && !was_pending) m_stale = (m_stale >= 255) ? 255 : m_stale + 1;
        if (!was_pending && upd_valid_in) begin
            m_stage[0] = int'(upd_direction_in) % 360;
            m_stage[1] = upd_player_x_in;
            m_stage[2] = upd_player_y_in;
            m_stage[3] = upd_opponent_x_in;
            m_stage[4] = upd_opponent_y_in;
            m_pending  = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk_in);
        if (rst_n_in) model_clock(); else model_reset();
        #1;
    endtask

    task automatic raster_random();
        hcount_in = 11'($urandom_range(1, 2047));
        vcount_in = 10'($urandom_range(0, 1023));
    endtask

    task automatic raster_commit();
        hcount_in = 11'd0;
        vcount_in = 10'(COMMIT_V);
    endtask

    task automatic drive_update(input int d, input int px, input int py, input int ox, input int oy);
        upd_valid_in      = 1'b1;
        upd_direction_in  = 9'(d);
        upd_player_x_in   = 11'(px);
        upd_player_y_in   = 11'(py);
        upd_opponent_x_in = 11'(ox);
        upd_opponent_y_in = 11'(oy);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        hcount_in = 11'd600; vcount_in = 10'd10;
        freeze_in = 1'b0; upd_valid_in = 1'b0;
        drive_update(0, 0, 0, 0, 0); upd_valid_in = 1'b0;
        tick(); tick();
        checks++;
        if ({direction_out, player_x_out, player_y_out, opponent_x_out, opponent_y_out} !== '0) begin
            errors++; $display("[TB] FAIL reset_active got dir=%0d px=%0d want all 0", direction_out, player_x_out);
        end
        checks++;
        if (upd_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", upd_ready_out); end
        checks++;
        if ({commit_out, view_active_out} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_flags got commit=%b view=%b want 0 0", commit_out, view_active_out);
        end
        checks++;
        if (frame_count_out !== 16'd0 || stale_count_out !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", frame_count_out, stale_count_out);
        end
        rst_n_in = 1'b1;
    endtask

    task automatic test_basic_commit();
        raster_random();
        drive_update(45, 1000, 900, 1100, 950);
        tick();
        upd_valid_in = 1'b0;
        checks++;
        if (upd_ready_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready got %b want 0", upd_ready_out); end
        for (int i = 0; i < 20; i++) begin
            raster_random();
            tick();
            checks++;
            if (direction_out !== 9'd0 || player_x_out !== 11'd0 || opponent_y_out !== 11'd0) begin
                errors++; $display("[TB] FAIL basic_hold got dir=%0d px=%0d oy=%0d want 0", direction_out, player_x_out, opponent_y_out);
            end
        end
        raster_commit();
        tick();
        checks++;
        if (direction_out !== 9'd45 || player_x_out !== 11'd1000 || player_y_out !== 11'd900 ||
            opponent_x_out !== 11'd1100 || opponent_y_out !== 11'd950) begin
            errors++;
            $display("[TB] FAIL basic_values got %0d/%0d/%0d/%0d/%0d want 45/1000/900/1100/950",
                     direction_out, player_x_out, player_y_out, opponent_x_out, opponent_y_out);
        end
        checks++;
        if (commit_out !== 1'b1) begin errors++; $display("[TB] FAIL basic_pulse_hi got %b want 1", commit_out); end
        raster_random();
        tick();
        checks++;
        if (commit_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_pulse_lo got %b want 0", commit_out); end
        checks++;
        if (upd_ready_out !== 1'b1 || frame_count_out !== 16'(m_frames)) begin
            errors++; $display("[TB] FAIL basic_after got ready=%b frames=%0d want 1/%0d", upd_ready_out, frame_count_out, m_frames);
        end
    endtask

    task automatic test_normalize();
        raster_random();
        drive_update(400, $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047));
        tick();
        upd_valid_in = 1'b0;
        raster_commit();
        tick();
        checks++;
        if (direction_out !== 9'd40) begin errors++; $display("[TB] FAIL normalize got %0d want 40", direction_out); end
        checks++;
        if (player_x_out !== 11'(m_show[1]) || opponent_y_out !== 11'(m_show[4])) begin
            errors++; $display("[TB] FAIL normalize_pos got %0d/%0d want %0d/%0d", player_x_out, opponent_y_out, m_show[1], m_show[4]);
        end
    endtask

    task automatic test_stale();
        int base_stale = m_stale;
        int base_frames = m_frames;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 5; i++) begin raster_random(); tick(); end
            raster_commit(); tick();
        end
        raster_random(); tick();
        checks++;
        if (stale_count_out !== 8'(base_stale + 3) || frame_count_out !== 16'(base_frames + 3)) begin
            errors++; $display("[TB] FAIL stale_counts got %0d/%0d want %0d/%0d", stale_count_out, frame_count_out, base_stale + 3, base_frames + 3);
        end
        checks++;
        if (direction_out !== 9'd40 || player_x_out !== 11'(m_show[1])) begin
            errors++; $display("[TB] FAIL stale_hold got dir=%0d px=%0d want 40/%0d", direction_out, player_x_out, m_show[1]);
        end
    endtask

    task automatic test_freeze();
        int base_stale = m_stale;
        int base_frames = m_frames;
        raster_random();
        drive_update(123, 11, 22, 33, 44);
        tick();
        upd_valid_in = 1'b0;
        freeze_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            raster_random(); tick();
            raster_commit(); tick();
            checks++;
            if (commit_out !== 1'b0 || direction_out !== 9'd40 || upd_ready_out !== 1'b0) begin
                errors++; $display("[TB] FAIL freeze_hold got commit=%b dir=%0d ready=%b want 0/40/0", commit_out, direction_out, upd_ready_out);
            end
            checks++;
            if (frame_count_out !== 16'(base_frames) || stale_count_out !== 8'(base_stale)) begin
                errors++; $display("[TB] FAIL freeze_counts got %0d/%0d want %0d/%0d", frame_count_out, stale_count_out, base_frames, base_stale);
            end
        end
        freeze_in = 1'b0;
        raster_random(); tick();
        raster_commit(); tick();
        checks++;
        if (commit_out !== 1'b1 || direction_out !== 9'd123 || opponent_y_out !== 11'd44 || frame_count_out !== 16'(base_frames + 1)) begin
            errors++; $display("[TB] FAIL freeze_release got commit=%b dir=%0d oy=%0d frames=%0d want 1/123/44/%0d",
                               commit_out, direction_out, opponent_y_out, frame_count_out, base_frames + 1);
        end
    endtask

    task automatic test_collision();
        int base_stale = m_stale;
        raster_random(); tick();
        raster_commit();
        drive_update(200, 501, 502, 503, 504);
        tick();
        checks++;
        if (stale_count_out !== 8'(base_stale + 1) || upd_ready_out !== 1'b0 || direction_out !== 9'd123) begin
            errors++; $display("[TB] FAIL collision_stale got stale=%0d ready=%b dir=%0d want %0d/0/123",
                               stale_count_out, upd_ready_out, direction_out, base_stale + 1);
        end
        drive_update(77, 1, 2, 3, 4);
        for (int i = 0; i < 4; i++) begin raster_random(); tick(); end
        upd_valid_in = 1'b0;
        raster_commit(); tick();
        checks++;
        if (direction_out !== 9'd200 || player_x_out !== 11'd501 || opponent_y_out !== 11'd504) begin
            errors++; $display("[TB] FAIL collision_values got %0d/%0d/%0d want 200/501/504", direction_out, player_x_out, opponent_y_out);
        end
    endtask

    task automatic test_view();
        int tab[6][3] = '{'{511, 0, 0}, '{512, 0, 1}, '{1023, 383, 1}, '{1024, 100, 0}, '{700, 384, 0}, '{512, 383, 1}};
        int prev = 0;
        raster_random(); hcount_in = 11'd100; tick();
        for (int i = 0; i < 6; i++) begin
            hcount_in = 11'(tab[i][0]);
            vcount_in = 10'(tab[i][1]);
            #2;
            checks++;
            if (view_active_out !== 1'(prev)) begin
                errors++; $display("[TB] FAIL view_latency entry %0d got %b want %0d", i, view_active_out, prev);
            end
            tick();
            checks++;
            if (view_active_out !== 1'(tab[i][2])) begin
                errors++; $display("[TB] FAIL view_window h=%0d v=%0d got %b want %0d", tab[i][0], tab[i][1], view_active_out, tab[i][2]);
            end
            prev = tab[i][2];
        end
    endtask

    task automatic test_stale_saturate();
        for (int f = 0; f < 270; f++) begin
            raster_random(); tick();
            raster_commit(); tick();
        end
        raster_random(); tick();
        checks++;
        if (stale_count_out !== 8'd255 || frame_count_out !== 16'(m_frames)) begin
            errors++; $display("[TB] FAIL stale_saturate got %0d/%0d want 255/%0d", stale_count_out, frame_count_out, m_frames);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 15) raster_commit(); else raster_random();
            freeze_in = ($urandom_range(0, 99) < 20);
            upd_valid_in = ($urandom_range(0, 99) < 30);
            upd_direction_in  = 9'($urandom_range(0, 511));
            upd_player_x_in   = 11'($urandom);
            upd_player_y_in   = 11'($urandom);
            upd_opponent_x_in = 11'($urandom);
            upd_opponent_y_in = 11'($urandom);
            tick();
            checks++;
            if (direction_out !== 9'(m_show[0]) || player_x_out !== 11'(m_show[1]) || player_y_out !== 11'(m_show[2]) ||
                opponent_x_out !== 11'(m_show[3]) || opponent_y_out !== 11'(m_show[4]) || commit_out !== m_commit ||
                view_active_out !== m_view || upd_ready_out !== !m_pending ||
                frame_count_out !== 16'(m_frames) || stale_count_out !== 8'(m_stale)) begin
                errors++;
                $display("[TB] FAIL random cyc %0d got dir=%0d px=%0d c=%b v=%b r=%b f=%0d s=%0d want dir=%0d px=%0d c=%b v=%b r=%b f=%0d s=%0d",
                         i, direction_out, player_x_out, commit_out, view_active_out, upd_ready_out, frame_count_out, stale_count_out,
                         m_show[0], m_show[1], m_commit, m_view, !m_pending, m_frames, m_stale);
            end
        end
        freeze_in = 1'b0; upd_valid_in = 1'b0;
    endtask

    task automatic test_async_reset();
        hcount_in = 11'd700; vcount_in = 10'd50;
        drive_update(90, 300, 301, 302, 303);
        tick();
        upd_valid_in = 1'b0;
        raster_commit(); tick();
        hcount_in = 11'd800; vcount_in = 10'd20;
        drive_update(10, 5, 6, 7, 8);
        tick();
        upd_valid_in = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({direction_out, player_x_out, player_y_out, opponent_x_out, opponent_y_out} !== '0 || upd_ready_out !== 1'b1) begin
            errors++; $display("[TB] FAIL async_reset_outputs got dir=%0d px=%0d ready=%b want 0/0/1", direction_out, player_x_out, upd_ready_out);
        end
        checks++;
        if (view_active_out !== 1'b0 || frame_count_out !== 16'd0 || stale_count_out !== 8'd0 || commit_out !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset_flags got v=%b f=%0d s=%0d c=%b want 0/0/0/0",
                               view_active_out, frame_count_out, stale_count_out, commit_out);
        end
        tick();
        rst_n_in = 1'b1;
        raster_commit(); tick();
        checks++;
        if (commit_out !== 1'b0 || direction_out !== 9'd0 || stale_count_out !== 8'd1 || frame_count_out !== 16'd1) begin
            errors++; $display("[TB] FAIL async_reset_discard got c=%b dir=%0d s=%0d f=%0d want 0/0/1/1",
                               commit_out, direction_out, stale_count_out, frame_count_out);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_commit();
        test_normalize();
        test_stale();
        test_freeze();
        test_collision();
        test_view();
        test_random();
        test_stale_saturate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
